// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the MixColumns datapath.
package aes_pkg;

  typedef logic [0:127] state_t;
  typedef logic [0:31]  word_t;

  // Reduction term of the AES field polynomial x^8+x^4+x^3+x+1
  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Multiply by 02 in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by 03 in GF(2^8)
  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward MixColumns for one 32-bit column (row 0 in the top byte).
module mix_column_word
  import aes_pkg::*;
(
  input  word_t i_col,
  output word_t o_col
);

  logic [7:0] w_b0, w_b1, w_b2, w_b3;

  assign w_b0 = i_col[0:7];
  assign w_b1 = i_col[8:15];
  assign w_b2 = i_col[16:23];
  assign w_b3 = i_col[24:31];

  // Circulant matrix rows {02 03 01 01} rotated right once per row
  assign o_col[0:7]   = xtime(w_b0)   ^ gf_mul3(w_b1) ^ w_b2          ^ w_b3;
  assign o_col[8:15]  = w_b0          ^ xtime(w_b1)   ^ gf_mul3(w_b2) ^ w_b3;
  assign o_col[16:23] = w_b0          ^ w_b1          ^ xtime(w_b2)   ^ gf_mul3(w_b3);
  assign o_col[24:31] = gf_mul3(w_b0) ^ w_b1          ^ w_b2          ^ xtime(w_b3);

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one column per clock through a single shared
// column multiplier, valid/ready on both sides, bypass for the final round.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int NCOLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);

  generate
    if (NCOLS != 4) begin : g_bad_ncols
      $error("mix_columns_seq: NCOLS must be 4 for AES");
    end
  endgenerate

  mc_state_e r_state;
  mc_state_e w_state_nxt;
  logic [1:0] r_col;
  state_t     r_work;
  word_t      w_col_in;
  word_t      w_col_out;
  logic       w_accept;

  assign w_accept = in_valid && in_ready;

  // Gather column r_col (bytes col, col+4, col+8, col+12) from the working state
  always_comb begin
    w_col_in = '0;
    for (int r = 0; r < 4; r++) begin
      w_col_in[8*r +: 8] = r_work[8*(4*r + int'(r_col)) +: 8];
    end
  end

  mix_column_word u_mix (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Working register and column counter: load on accept, rewrite one column per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_col  <= 2'd0;
    end else if (w_accept) begin
      r_work <= in_data;
      r_col  <= 2'd0;
    end else if (r_state == CALC) begin
      for (int r = 0; r < 4; r++) begin
        r_work[8*(4*r + int'(r_col)) +: 8] <= w_col_out[8*r +: 8];
      end
      r_col <= r_col + 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; a DONE block handed off while a new one arrives reloads without a bubble
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = in_bypass ? DONE : CALC;
      end
      CALC: begin
        if (r_col == 2'd3) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = in_bypass ? DONE : CALC;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the working register stays hidden until DONE
  always_comb begin
    in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    out_valid = (r_state == DONE);
    out_data  = (r_state == DONE) ? r_work : '0;
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: directed FIPS-197 / bypass / backpressure /
// reset cases plus a random stream checked against a reference and its inverse.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_data = '0;
  logic         in_bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_data;

  localparam logic [0:127] FIPS_IN  = 128'hdbf2012d_130a0126_53220131_455c014c;
  localparam logic [0:127] FIPS_OUT = 128'h8e9f014d_4ddc017e_a15801bd_bc9d01f8;
  localparam logic [0:127] ALL_C6   = {16{8'hc6}};

  typedef struct {
    logic [0:127] din;
    logic         byp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_chk = 0;
  int  n_fail = 0;

  mix_columns_seq #(.NCOLS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product; row0 holds the first matrix row, later rows rotate it
  function automatic logic [0:127] mat_ref(input logic [0:127] s, input logic [0:31] row0);
    logic [0:127] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gm(row0[8*((k - r + 4) % 4) +: 8], s[8*(4*k + c) +: 8]);
        o[8*(4*r + c) +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix_ref(input logic [0:127] s);
    return mat_ref(s, 32'h02030101);
  endfunction

  function automatic logic [0:127] inv_ref(input logic [0:127] s);
    return mat_ref(s, 32'h0e0b0d09);
  endfunction

  // Output monitor: one pop per cycle in which a result is handed off
  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid) begin
        chk("idle_zero", out_data, 128'd0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_depth", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("data", out_data, mon_e.byp ? mon_e.din : mix_ref(mon_e.din));
          if (!mon_e.byp) chk("roundtrip", inv_ref(out_data), mon_e.din);
        end
      end
    end
  end

  // Present one block and hold it until taken; returns just after the accept edge
  task automatic send(input logic [0:127] d, input logic b);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_bypass = b;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("accept_timeout", t, 0);
    else sb.push_back(sb_t'{din: d, byp: b});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (0 = valid right after accept)
  task automatic edges_to_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sent;
    int t;
    logic [0:127] held;
    logic [0:127] d2;

    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // FIPS-197 reference columns
    send(FIPS_IN, 1'b0);
    edges_to_valid(n);
    chk("fips_lat", n, 4);
    chk("fips_data", out_data, FIPS_OUT);
    @(posedge clk); #1;

    // Bypass: DONE is entered on the accept edge itself
    send(FIPS_IN, 1'b1);
    edges_to_valid(n);
    chk("byp_lat", n, 0);
    chk("byp_data", out_data, FIPS_IN);
    @(posedge clk); #1;

    // Backpressure then back-to-back handoff
    out_ready = 1'b0;
    send(FIPS_IN, 1'b0);
    edges_to_valid(n);
    chk("bp_lat", n, 4);
    held = out_data;
    chk("bp_data", held, FIPS_OUT);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_hold", out_data, held);
      chk("bp_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 chk("b2b_ready", in_ready, 1'b1);
    d2 = {$urandom, $urandom, $urandom, $urandom};
    send(d2, 1'b0);
    edges_to_valid(n);
    chk("b2b_lat", n, 4);
    chk("b2b_data", out_data, mix_ref(d2));
    @(posedge clk); #1;

    // Asynchronous reset two cycles into CALC
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send(ALL_C6, 1'b0);
    edges_to_valid(n);
    chk("c6_lat", n, 4);
    chk("c6_data", out_data, ALL_C6);
    @(posedge clk); #1;

    // Random stream at random duty on both sides
    sent = 0;
    while (sent < 1000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_bypass = 1'b0;
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(sb_t'{din: in_data, byp: 1'b0});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
